// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: load/store type codes carried through EMReg.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LW   = 3'd1,
    LD_LB   = 3'd2,
    LD_LBU  = 3'd3,
    LD_LH   = 3'd4,
    LD_LHU  = 3'd5
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_SW   = 2'd0,
    ST_SH   = 2'd1,
    ST_SB   = 2'd2,
    ST_RSVD = 2'd3
  } st_type_e;

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension for the MEM stage.
module dm_load_ext
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      lane_i,
  input  logic [2:0]      load_type_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    result_o = '0;
    case (ld_type_e'(load_type_i))
      LD_LW:   result_o = word_i;
      LD_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result_o = {24'h0, byte_sel};
      LD_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result_o = {16'h0, half_sel};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_stage.sv
// MEM-stage data memory: byte-lane stores committed on posedge, combinational
// extended loads, and address error flagging for misaligned/out-of-range accesses.
module dm_stage
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            MemWrite,
  input  logic [1:0]      StoreType,
  input  logic [2:0]      LoadType,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
  input  logic [XLEN-1:0] Pc,
  output logic [XLEN-1:0] ReadData,
  output logic            AddrErr
);

  localparam logic [XLEN-1:0] BYTE_LIMIT = XLEN'(4 * DEPTH_WORDS);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] mem_d;

  st_type_e        st_type;
  logic            ld_active;
  logic            ld_mis;
  logic            st_mis;
  logic            out_of_range;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] st_data;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] old_word;
  logic [XLEN-1:0] ext_word;
  logic            store_commit;

  assign st_type      = st_type_e'(StoreType);
  assign word_idx     = Addr[AW+1:2];
  assign old_word     = mem_q[word_idx];
  assign out_of_range = (Addr >= BYTE_LIMIT);

  // Load decode: activity and alignment requirement per load width.
  always_comb begin
    ld_active = 1'b0;
    ld_mis    = 1'b0;
    case (ld_type_e'(LoadType))
      LD_LW: begin
        ld_active = 1'b1;
        ld_mis    = |Addr[1:0];
      end
      LD_LH, LD_LHU: begin
        ld_active = 1'b1;
        ld_mis    = Addr[0];
      end
      LD_LB, LD_LBU: ld_active = 1'b1;
      default: ld_active = 1'b0;
    endcase
  end

  // Store decode: byte enables, lane-replicated data, alignment requirement.
  always_comb begin
    st_mis  = 1'b0;
    byte_en = 4'b0000;
    st_data = WriteData;
    case (st_type)
      ST_SW: begin
        st_mis  = |Addr[1:0];
        byte_en = 4'b1111;
      end
      ST_SH: begin
        st_mis  = Addr[0];
        byte_en = Addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{WriteData[15:0]}};
      end
      ST_SB: begin
        byte_en = 4'b0001 << Addr[1:0];
        st_data = {4{WriteData[7:0]}};
      end
      default: byte_en = 4'b0000;
    endcase
  end

  assign AddrErr = (ld_active | MemWrite) &
                   ((ld_active & ld_mis) | (MemWrite & st_mis) | out_of_range);

  assign store_commit = MemWrite & ~AddrErr & (st_type != ST_RSVD);

  always_comb begin
    mem_d = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (byte_en[b]) mem_d[8*b +: 8] = st_data[8*b +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (store_commit) begin
      mem_q[word_idx] <= mem_d;
    end
  end

  dm_load_ext u_load_ext (
    .word_i      (old_word),
    .lane_i      (Addr[1:0]),
    .load_type_i (LoadType),
    .result_o    (ext_word)
  );

  assign ReadData = (ld_active & ~AddrErr) ? ext_word : '0;

`ifndef SYNTHESIS
  // Write log of every committed store, for trace comparison against the ISS.
  always @(posedge Clk) begin
    if (!Reset && store_commit) begin
      $display("@%h: *%h <= %h", Pc, {Addr[31:2], 2'b00}, mem_d);
    end
  end
`endif

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: directed load/store scenarios plus a short
// randomized word/byte traffic run against a bench-side memory model.
module tb_dm_stage;
  import mips_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MemWrite;
  logic [1:0]  StoreType;
  logic [2:0]  LoadType;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] Pc;
  logic [31:0] ReadData;
  logic        AddrErr;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [31:0] mdl [64];

  always #5 Clk = ~Clk;

  dm_stage dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MemWrite  (MemWrite),
    .StoreType (StoreType),
    .LoadType  (LoadType),
    .Addr      (Addr),
    .WriteData (WriteData),
    .Pc        (Pc),
    .ReadData  (ReadData),
    .AddrErr   (AddrErr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one MEM-stage cycle, push its expectation, compare mid-cycle, then cross the edge.
  task automatic op(input string tag, input logic rst, input logic mw, input logic [1:0] st,
                    input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    exp_t g;
    Reset     = rst;
    MemWrite  = mw;
    StoreType = st;
    LoadType  = lt;
    Addr      = a;
    WriteData = wd;
    Pc        = Pc + 32'd4;
    e.tag = tag;
    e.rd  = exp_rd;
    e.err = exp_err;
    exp_q.push_back(e);
    @(negedge Clk);
    g = exp_q.pop_front();
    check_eq({g.tag, ".rd"}, ReadData, g.rd);
    check_eq({g.tag, ".err"}, 32'(AddrErr), 32'(g.err));
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Pc = 32'h0040_0000;
    Reset = 1'b1; MemWrite = 1'b0; StoreType = 2'd3; LoadType = 3'd0;
    Addr = '0; WriteData = '0;
    repeat (2) @(posedge Clk);
    #1;

    // Scenario 1: reset contents
    op("rst_lw0",   0, 0, ST_SW, LD_LW,   32'h0,   32'h0, 32'h0, 0);
    op("rst_lw10",  0, 0, ST_SW, LD_LW,   32'h10,  32'h0, 32'h0, 0);
    op("rst_lwffc", 0, 0, ST_SW, LD_LW,   32'hFFC, 32'h0, 32'h0, 0);

    // Scenario 2-4: word, byte, half stores and extended loads
    op("sw20",      0, 1, ST_SW, LD_NONE, 32'h20, 32'h12345678, 32'h0, 0);
    op("lw20",      0, 0, ST_SW, LD_LW,   32'h20, 32'h0, 32'h12345678, 0);
    op("sb21",      0, 1, ST_SB, LD_NONE, 32'h21, 32'hFFFFFF80, 32'h0, 0);
    op("lw20_sb",   0, 0, ST_SW, LD_LW,   32'h20, 32'h0, 32'h12348078, 0);
    op("lb21",      0, 0, ST_SW, LD_LB,   32'h21, 32'h0, 32'hFFFFFF80, 0);
    op("lbu21",     0, 0, ST_SW, LD_LBU,  32'h21, 32'h0, 32'h00000080, 0);
    op("sh22",      0, 1, ST_SH, LD_NONE, 32'h22, 32'h0000BEEF, 32'h0, 0);
    op("lw20_sh",   0, 0, ST_SW, LD_LW,   32'h20, 32'h0, 32'hBEEF8078, 0);
    op("lh22",      0, 0, ST_SW, LD_LH,   32'h22, 32'h0, 32'hFFFFBEEF, 0);
    op("lhu22",     0, 0, ST_SW, LD_LHU,  32'h22, 32'h0, 32'h0000BEEF, 0);
    op("lh20",      0, 0, ST_SW, LD_LH,   32'h20, 32'h0, 32'hFFFF8078, 0);
    op("lb20",      0, 0, ST_SW, LD_LB,   32'h20, 32'h0, 32'h00000078, 0);
    op("lbu23",     0, 0, ST_SW, LD_LBU,  32'h23, 32'h0, 32'h000000BE, 0);

    // Scenario 5: misaligned, out-of-range, reserved codes
    op("sw23_mis",  0, 1, ST_SW, LD_NONE, 32'h23, 32'hDEADBEEF, 32'h0, 1);
    op("lh21_mis",  0, 0, ST_SW, LD_LH,   32'h21, 32'h0, 32'h0, 1);
    op("lw22_mis",  0, 0, ST_SW, LD_LW,   32'h22, 32'h0, 32'h0, 1);
    op("lw20_kept", 0, 0, ST_SW, LD_LW,   32'h20, 32'h0, 32'hBEEF8078, 0);
    op("sw1000",    0, 1, ST_SW, LD_NONE, 32'h1000, 32'hCAFEF00D, 32'h0, 1);
    op("lw0_alias", 0, 0, ST_SW, LD_LW,   32'h0,    32'h0, 32'h0, 0);
    op("lw1000",    0, 0, ST_SW, LD_LW,   32'h1000, 32'h0, 32'h0, 1);
    op("lbfff",     0, 0, ST_SW, LD_LB,   32'hFFF,  32'h0, 32'h0, 0);
    op("st_rsvd",   0, 1, 2'd3,  LD_LW,   32'h20, 32'h11111111, 32'hBEEF8078, 0);
    op("lw20_rsvd", 0, 0, ST_SW, LD_LW,   32'h20, 32'h0, 32'hBEEF8078, 0);
    op("ld_rsvd",   0, 0, ST_SW, 3'd6,    32'h20, 32'h0, 32'h0, 0);
    op("idle_mis",  0, 0, ST_SW, LD_NONE, 32'h23, 32'h0, 32'h0, 0);

    // Scenario 6: reset beats store; read-before-write on the same word
    op("sw40_rst",  1, 1, ST_SW, LD_NONE, 32'h40, 32'hAAAA5555, 32'h0, 0);
    op("lw40_rst",  0, 0, ST_SW, LD_LW,   32'h40, 32'h0, 32'h0, 0);
    op("lw20_rst",  0, 0, ST_SW, LD_LW,   32'h20, 32'h0, 32'h0, 0);
    op("sw40_rbw",  0, 1, ST_SW, LD_LW,   32'h40, 32'h11223344, 32'h0, 0);
    op("lw40_new",  0, 0, ST_SW, LD_LW,   32'h40, 32'h0, 32'h11223344, 0);

    // Randomized word/byte traffic over the first 64 words
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    mdl[16] = 32'h11223344;
    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
      logic [5:0]  w;
      logic [1:0]  ln;
      kind = int'($urandom_range(0, 2));
      w    = 6'($urandom_range(0, 63));
      ln   = 2'($urandom_range(0, 3));
      d    = $urandom;
      if (kind == 0) begin
        a = {24'h0, w, 2'b00};
        op("rnd_sw", 0, 1, ST_SW, LD_NONE, a, d, 32'h0, 0);
        mdl[w] = d;
      end else if (kind == 1) begin
        a = {24'h0, w, ln};
        op("rnd_sb", 0, 1, ST_SB, LD_NONE, a, d, 32'h0, 0);
        mdl[w][8*ln +: 8] = d[7:0];
      end else begin
        a = {24'h0, w, 2'b00};
        op("rnd_lw", 0, 0, ST_SW, LD_LW, a, 32'h0, mdl[w], 0);
      end
    end
    for (int i = 0; i < 64; i++) begin
      op("sweep_lw", 0, 0, ST_SW, LD_LW, 32'(i * 4), 32'h0, mdl[i], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
